multicycle_control: RTL and testbench
=====================================

# multicycle_control

- Multicycle control FSM for the CPU core; drives the datapath and the ALU's `alucontrol` port.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Paces memory accesses with a request/ready handshake.
- Decodes opcode/funct into the 3-bit ALU operation code the ALU consumes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- instr  in  32  current IR contents; opcode = instr[31:26], funct = instr[5:0]; stable except when irwrite fires.
- zero  in  1  ALU result == 0 (combinational from datapath).
- mem_ready  in  1  memory completes the access requested this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write when mem_req=1.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  latch IR.
- pcen  out  1  PC write enable.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- alusrca  out  1  ALU A select: 0 = PC, 1 = regA.
- alusrcb  out  2  ALU B select: 00 = regB, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
- immext  out  1  immediate extension: 0 = sign, 1 = zero.
- regdst  out  1  destination register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = memory data.
- regwrite  out  1  register file write.
- alucontrol  out  3  ALU op code.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- state  out  4  current state (debug).

## Operation
**ALU codes**
- 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll, 100 sra, 101 lui.
- Shifts take shamt from instr[10:6]; this is datapath wiring, not a controller output.

**Supported opcodes**
- 000000 R-type. Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 000011 sra.
- 100011 lw, 101011 sw, 000100 beq, 000010 j.
- 001000 addi, 001010 slti, 001100 andi, 001101 ori, 001111 lui.

**Defaults**
- Every output is 0 unless listed for the state; alucontrol defaults to 010.

**States** (encoding in parentheses)
- IDLE(0): all defaults; next FETCH.
- FETCH(1): mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010.
  - If mem_ready: irwrite=1, pcen=1, pcsrc=00; next DECODE.
  - Else stay in FETCH with irwrite=pcen=0.
- DECODE(2): alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state:
  - lw/sw → MEMADR; R-type (supported funct) → RTYPEEX; beq → BEQEX; I-ALU → IEX; j → JEX.
  - Anything else → illegal=1, next FETCH.
- MEMADR(3): alusrca=1, alusrcb=10, immext=0, add; lw → MEMRD, sw → MEMWR.
- MEMRD(4): mem_req=1, iord=1; on mem_ready → MEMWB, else hold.
- MEMWB(5): regwrite=1, regdst=0, memtoreg=1; → FETCH.
- MEMWR(6): mem_req=1, mem_we=1, iord=1; on mem_ready → FETCH, else hold.
- RTYPEEX(7): alusrca=1, alusrcb=00, alucontrol from funct; → RTYPEWB.
- RTYPEWB(8): regwrite=1, regdst=1, memtoreg=0; → FETCH.
- BEQEX(9): alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero (combinational); → FETCH.
- IEX(10): alusrca=1, alusrcb=10; → IWB.
  - addi: 010, immext=0. slti: 111, immext=0. andi: 000, immext=1. ori: 001, immext=1. lui: 101, immext=1.
- IWB(11): regwrite=1, regdst=0, memtoreg=0; → FETCH.
- JEX(12): pcen=1, pcsrc=10; → FETCH.
- Codes 13–15 are unreachable; treat as IDLE (next FETCH).

## Timing
- State register is updated on rising clk; reset is asynchronous.
- rst_n low forces state=IDLE immediately. All strobes read 0 and alucontrol 010 during reset and in the first cycle after release.
- Outputs are Moore (state plus instr). Exceptions, combinational with their inputs:
  - pcen in BEQEX follows zero.
  - irwrite/pcen in FETCH follow mem_ready.
- Reset asserted mid-instruction (including mid-handshake) abandons the instruction; no partial regwrite is issued after reset.
- mem_req holds high, with iord/mem_we constant, until the cycle mem_ready=1. mem_ready while mem_req=0 is ignored.
- Latency with zero-wait memory:
  - lw 5 cycles; sw, R-type and I-ALU 4; beq and j 3; illegal 2.
  - Each memory wait cycle adds 1.
- illegal is high only in the DECODE cycle.

## Test plan
- Reset release with mem_ready=1, instr=0x00851020 (add) → IDLE, FETCH, DECODE, RTYPEEX (alucontrol=010), RTYPEWB (regwrite=1, regdst=1), FETCH.
- lw 0x8C820004 with mem_ready low 2 cycles in MEMRD → MEMRD holds 3 cycles, mem_req/iord=1 throughout; MEMWB regwrite=1, memtoreg=1; 7 cycles total from FETCH.
- beq 0x10850003 with zero=1 → BEQEX pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 → pcen=0.
- I-ALU sweep: ori 0x34A5FFFF → IEX alucontrol=001, immext=1; lui 0x3C051234 → 101; slti → 111 with immext=0. Each followed by IWB regwrite=1, regdst=0.
- R-type sweep: funct sll, sra, sub, and, slt → RTYPEEX alucontrol 011, 100, 110, 000, 111. Opcode 0x3F or funct 0x3F → illegal=1 for one cycle, back to FETCH, no regwrite.
- rst_n pulsed low while in MEMWR waiting on mem_ready → state=IDLE asynchronously, mem_req/mem_we drop the same cycle, resumes FETCH after release.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory handshake and ALU op decode
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        irwrite,
    output logic        pcen,
    output logic [1:0]  pcsrc,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic        immext,
    output logic        regdst,
    output logic        memtoreg,
    output logic        regwrite,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_IEX     = 4'd10,
        S_IWB     = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRA = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    state_t     state_q, state_d;
    logic [5:0] op, fn;
    logic       rtype_ok, iop_ok, iop_immext;
    logic [2:0] rtype_alu, iop_alu;

    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign state = state_q;

    // Funct and I-ALU opcode decode; the *_ok flags gate DECODE's dispatch.
    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = ALU_ADD;
        case (fn)
            6'b100000: rtype_alu = ALU_ADD;
            6'b100010: rtype_alu = ALU_SUB;
            6'b100100: rtype_alu = ALU_AND;
            6'b100101: rtype_alu = ALU_OR;
            6'b101010: rtype_alu = ALU_SLT;
            6'b000000: rtype_alu = ALU_SLL;
            6'b000011: rtype_alu = ALU_SRA;
            default:   rtype_ok  = 1'b0;
        endcase
    end

    always_comb begin
        iop_ok     = 1'b1;
        iop_alu    = ALU_ADD;
        iop_immext = 1'b0;
        case (op)
            OP_ADDI: iop_alu = ALU_ADD;
            OP_SLTI: iop_alu = ALU_SLT;
            OP_ANDI: begin iop_alu = ALU_AND; iop_immext = 1'b1; end
            OP_ORI:  begin iop_alu = ALU_OR;  iop_immext = 1'b1; end
            OP_LUI:  begin iop_alu = ALU_LUI; iop_immext = 1'b1; end
            default: iop_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        immext     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed here so BEQEX can select ALUOut.
                alusrcb = 2'b11;
                if (op == OP_LW || op == OP_SW)      state_d = S_MEMADR;
                else if (op == OP_RTYPE && rtype_ok) state_d = S_RTYPEEX;
                else if (op == OP_BEQ)               state_d = S_BEQEX;
                else if (op == OP_J)                 state_d = S_JEX;
                else if (iop_ok)                     state_d = S_IEX;
                else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = rtype_alu;
                state_d    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                state_d    = S_FETCH;
            end
            S_IEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = iop_alu;
                immext     = iop_immext;
                state_d    = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                pcen    = 1'b1;
                pcsrc   = 2'b10;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, irwrite, pcen;
    logic [1:0]  pcsrc;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic        immext, regdst, memtoreg, regwrite;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [3:0]  state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite), .pcen(pcen),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .immext(immext),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immext;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic [2:0] alucontrol;
        logic       illegal;
    } outs_t;

    typedef struct packed {
        logic [31:0] ins;
        logic [3:0]  st;
        outs_t       o;
        logic        rdy;
        logic        zr;
    } cyc_t;

    outs_t obs_o;
    assign obs_o = {mem_req, mem_we, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                    immext, regdst, memtoreg, regwrite, alucontrol, illegal};

    cyc_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_J = 4, C_I = 5, C_ILL = 6;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc_no, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t dflt();
        outs_t o;
        o = '0;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    task automatic push(input logic [31:0] ins, input logic [3:0] st, input outs_t o,
                        input logic rdy, input logic zr);
        cyc_t c;
        c.ins = ins; c.st = st; c.o = o; c.rdy = rdy; c.zr = zr;
        exp_q.push_back(c);
    endtask

    // Expected cycle-by-cycle trace of one instruction, built from the instruction class.
    task automatic gen(input logic [31:0] ins, input int fwait, input int mwait, input logic z);
        logic [5:0] op, fn;
        int         cls;
        logic [2:0] ac;
        logic       ie;
        outs_t      o;
        op = ins[31:26];
        fn = ins[5:0];
        ac = 3'b010;
        ie = 1'b0;
        cls = C_ILL;
        case (op)
            6'h00: begin
                cls = C_R;
                case (fn)
                    6'h20: ac = 3'b010;
                    6'h22: ac = 3'b110;
                    6'h24: ac = 3'b000;
                    6'h25: ac = 3'b001;
                    6'h2A: ac = 3'b111;
                    6'h00: ac = 3'b011;
                    6'h03: ac = 3'b100;
                    default: cls = C_ILL;
                endcase
            end
            6'h23: cls = C_LW;
            6'h2B: cls = C_SW;
            6'h04: cls = C_BEQ;
            6'h02: cls = C_J;
            6'h08: begin cls = C_I; ac = 3'b010; ie = 1'b0; end
            6'h0A: begin cls = C_I; ac = 3'b111; ie = 1'b0; end
            6'h0C: begin cls = C_I; ac = 3'b000; ie = 1'b1; end
            6'h0D: begin cls = C_I; ac = 3'b001; ie = 1'b1; end
            6'h0F: begin cls = C_I; ac = 3'b101; ie = 1'b1; end
            default: cls = C_ILL;
        endcase
        for (int i = 0; i <= fwait; i++) begin
            o = dflt(); o.mem_req = 1'b1; o.alusrcb = 2'b01;
            if (i == fwait) begin o.irwrite = 1'b1; o.pcen = 1'b1; end
            push(ins, 4'd1, o, i == fwait, rb());
        end
        o = dflt(); o.alusrcb = 2'b11; o.illegal = (cls == C_ILL);
        push(ins, 4'd2, o, rb(), rb());
        case (cls)
            C_LW, C_SW: begin
                o = dflt(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                push(ins, 4'd3, o, rb(), rb());
                for (int i = 0; i <= mwait; i++) begin
                    o = dflt(); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (cls == C_SW);
                    push(ins, (cls == C_LW) ? 4'd4 : 4'd6, o, i == mwait, rb());
                end
                if (cls == C_LW) begin
                    o = dflt(); o.regwrite = 1'b1; o.memtoreg = 1'b1;
                    push(ins, 4'd5, o, rb(), rb());
                end
            end
            C_R: begin
                o = dflt(); o.alusrca = 1'b1; o.alucontrol = ac;
                push(ins, 4'd7, o, rb(), rb());
                o = dflt(); o.regwrite = 1'b1; o.regdst = 1'b1;
                push(ins, 4'd8, o, rb(), rb());
            end
            C_BEQ: begin
                o = dflt(); o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z;
                push(ins, 4'd9, o, rb(), z);
            end
            C_I: begin
                o = dflt(); o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = ac; o.immext = ie;
                push(ins, 4'd10, o, rb(), rb());
                o = dflt(); o.regwrite = 1'b1;
                push(ins, 4'd11, o, rb(), rb());
            end
            C_J: begin
                o = dflt(); o.pcen = 1'b1; o.pcsrc = 2'b10;
                push(ins, 4'd12, o, rb(), rb());
            end
            default: ;
        endcase
    endtask

    task automatic run_n(input int n);
        cyc_t c;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            c = exp_q.pop_front();
            @(negedge clk);
            instr = c.ins; mem_ready = c.rdy; zero = c.zr;
            #1;
            cyc_no++;
            check("state", 32'(state), 32'(c.st));
            check("outs", 32'(obs_o), 32'(c.o));
        end
    endtask

    task automatic run_q();
        run_n(exp_q.size());
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  op, fn;
        r = $urandom;
        if ($urandom_range(0, 9) < 2) return r;
        case ($urandom_range(0, 9))
            0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04; 4: op = 6'h02;
            5: op = 6'h08; 6: op = 6'h0A; 7: op = 6'h0C; 8: op = 6'h0D; default: op = 6'h0F;
        endcase
        case ($urandom_range(0, 7))
            0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
            4: fn = 6'h2A; 5: fn = 6'h00; 6: fn = 6'h03; default: fn = r[5:0];
        endcase
        return {op, r[25:6], fn};
    endfunction

    initial begin
        rst_n = 1'b0; instr = 32'h00851020; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("rst_state", 32'(state), 32'd0);
            check("rst_outs", 32'(obs_o), 32'(dflt()));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_state", 32'(state), 32'd0);
        check("rel_outs", 32'(obs_o), 32'(dflt()));

        gen(32'h00851020, 0, 0, 1'b0);
        gen(32'h8C820004, 0, 2, 1'b0);
        gen(32'h10850003, 0, 0, 1'b1);
        gen(32'h10850003, 1, 0, 1'b0);
        gen(32'h34A5FFFF, 0, 0, 1'b0);
        gen(32'h3C051234, 0, 0, 1'b0);
        gen(32'h28A50005, 0, 0, 1'b0);
        gen(32'h00052080, 0, 0, 1'b0);
        gen(32'h00052083, 0, 0, 1'b0);
        gen(32'h00851022, 0, 0, 1'b0);
        gen(32'h00851024, 0, 0, 1'b0);
        gen(32'h0085102A, 0, 0, 1'b0);
        gen(32'hFC000000, 0, 0, 1'b0);
        gen(32'h0000003F, 2, 0, 1'b0);
        gen(32'h08000010, 0, 0, 1'b0);
        gen(32'hAC820008, 1, 1, 1'b0);
        run_q();

        for (int k = 0; k < 40; k++) begin
            gen(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rb());
            run_q();
        end

        // Reset in the middle of a stalled store.
        gen(32'hAC820008, 0, 8, 1'b0);
        run_n(6);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_outs", 32'(obs_o), 32'(dflt()));
        exp_q.delete();
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("hold_rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel2_state", 32'(state), 32'd0);
        check("rel2_outs", 32'(obs_o), 32'(dflt()));
        gen(32'h00851020, 0, 0, 1'b0);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
